// File: rtl/de0_pkg.sv
// Shared constants for the DE0 memory viewer: segment table, FSM encoding and
// the digit-count helper.
package de0_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    function automatic int ceil_div4(input int n);
        return (n + 3) / 4;
    endfunction

endpackage

// File: rtl/hex_to_fnd.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex_to_fnd
    import de0_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_nib];

endmodule

// File: rtl/de0_memory_viewer.sv
// Self-initialising RAM viewer: browse, key-triggered write and timed auto-scan,
// with address and data shown as hex on active-low 7-segment digits.
module de0_memory_viewer
    import de0_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int SCAN_DIV = 50_000_000
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [ADDR_W-1:0]                               addr_sw,
    input  logic [DATA_W-1:0]                               data_sw,
    input  logic                                            wr_key,
    input  logic                                            scan_en,
    output logic                                            ready,
    output logic [7*(ceil_div4(ADDR_W)+ceil_div4(DATA_W))-1:0] fnd
);

    localparam int AD     = ceil_div4(ADDR_W);
    localparam int DD     = ceil_div4(DATA_W);
    localparam int ND     = AD + DD;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int TICK_W = $clog2(SCAN_DIV);
    localparam int APW    = 4 * AD;
    localparam int DPW    = 4 * DD;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_init_addr;
    logic [ADDR_W-1:0]   r_scan_addr;
    logic [TICK_W-1:0]   r_tick;
    logic                r_ready;

    logic                r_key_meta;
    logic                r_key_sync;
    logic                r_key_prev;

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   r_rd_data;
    logic [ADDR_W-1:0]   r_view_q;
    logic                r_disp_valid;
    logic [7*ND-1:0]     r_fnd;

    logic                w_key_rise;
    logic                w_we;
    logic [ADDR_W-1:0]   w_waddr;
    logic [DATA_W-1:0]   w_wdata;
    logic [ADDR_W-1:0]   w_view_addr;
    logic [DPW-1:0]      w_data_pad;
    logic [APW-1:0]      w_addr_pad;
    logic [7*ND-1:0]     w_seg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_INIT;
            r_init_addr <= '0;
            r_scan_addr <= '0;
            r_tick      <= '0;
            r_ready     <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_init_addr <= r_init_addr + 1'b1;
                    if (&r_init_addr) begin
                        r_ready <= 1'b1;
                        if (scan_en) begin
                            r_state     <= ST_SCAN;
                            r_scan_addr <= addr_sw;
                            r_tick      <= '0;
                        end else begin
                            r_state <= ST_MANUAL;
                        end
                    end
                end
                ST_MANUAL: begin
                    if (scan_en) begin
                        r_state     <= ST_SCAN;
                        r_scan_addr <= addr_sw;
                        r_tick      <= '0;
                    end
                end
                ST_SCAN: begin
                    if (!scan_en) begin
                        r_state <= ST_MANUAL;
                        r_tick  <= '0;
                    end else if (r_tick == TICK_LAST) begin
                        r_tick      <= '0;
                        r_scan_addr <= r_scan_addr + 1'b1;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Key is asynchronous: two flops for metastability, a third for the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_meta <= 1'b0;
            r_key_sync <= 1'b0;
            r_key_prev <= 1'b0;
        end else begin
            r_key_meta <= wr_key;
            r_key_sync <= r_key_meta;
            r_key_prev <= r_key_sync;
        end
    end

    assign w_key_rise  = r_key_sync & ~r_key_prev;
    assign w_we        = (r_state == ST_INIT) || (w_key_rise && (r_state == ST_MANUAL));
    assign w_waddr     = (r_state == ST_INIT) ? r_init_addr : addr_sw;
    assign w_wdata     = (r_state == ST_INIT) ? DATA_W'(r_init_addr) : data_sw;
    assign w_view_addr = (r_state == ST_SCAN) ? r_scan_addr : addr_sw;

    // Read samples the old word when reading and writing the same address.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
        r_rd_data <= r_mem[w_view_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_view_q     <= '0;
            r_disp_valid <= 1'b0;
            r_fnd        <= {ND{SEG_BLANK}};
        end else begin
            r_view_q     <= w_view_addr;
            r_disp_valid <= (r_state != ST_INIT);
            r_fnd        <= r_disp_valid ? w_seg : {ND{SEG_BLANK}};
        end
    end

    assign w_data_pad = DPW'(r_rd_data);
    assign w_addr_pad = APW'(r_view_q);

    for (genvar g = 0; g < ND; g++) begin : g_digit
        if (g < DD) begin : g_data
            hex_to_fnd u_dec (
                .i_nib (w_data_pad[4*g +: 4]),
                .o_seg (w_seg[7*g +: 7])
            );
        end else begin : g_addr
            hex_to_fnd u_dec (
                .i_nib (w_addr_pad[4*(g-DD) +: 4]),
                .o_seg (w_seg[7*g +: 7])
            );
        end
    end

    assign ready = r_ready;
    assign fnd   = r_fnd;

endmodule
